mem_bus_arbiter: RTL

//  Shares one memory-side request port between the core's instruction fetch (ibus) and load/store (dbus) masters.

---
 rtl/mem_bus_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one memory-side request port between the instruction-fetch
//   master (ibus) and the load/store master (dbus). dbus normally wins
//   contention because a pending load/store stalls execution. A saturating
//   starvation counter forces an ibus grant after STARVE_LIMIT back-to-back
//   dbus wins while ibus was waiting. One transaction is outstanding at a
//   time. The winning request is registered, so m_* stays stable downstream.
//
// Ports
//   clk, reset                  clock (rising edge), async active-high reset
//   i_valid/i_addr/i_size       ibus request, held until i_data_ok
//   i_addr_ok/i_data_ok         ibus accept / completion pulses
//   d_valid/d_addr/d_size       dbus request, held until d_data_ok
//   d_strobe/d_wdata            dbus byte enables (0 = read) and store data
//   d_addr_ok/d_data_ok         dbus accept / completion pulses
//   rdata                       read data, meaningful with a data_ok pulse
//   m_valid/m_addr/m_size       downstream request and registered owner fields
//   m_strobe/m_wdata            registered strobe (0 for ibus) and store data
//   m_addr_ok/m_data_ok/m_rdata downstream handshake and read data
module mem_bus_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_valid,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic [2:0]          i_size,
    output logic                i_addr_ok,
    output logic                i_data_ok,
    input  logic                d_valid,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [2:0]          d_size,
    input  logic [DATA_W/8-1:0] d_strobe,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_addr_ok,
    output logic                d_data_ok,
    output logic [DATA_W-1:0]   rdata,
    output logic                m_valid,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [2:0]          m_size,
    output logic [DATA_W/8-1:0] m_strobe,
    output logic [DATA_W-1:0]   m_wdata,
    input  logic                m_addr_ok,
    input  logic                m_data_ok,
    input  logic [DATA_W-1:0]   m_rdata
);

    localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       owner_d;      // 1: dbus owns the current transaction
    logic [3:0] starve_cnt;
    logic       req_any;
    logic       grant_d;
    logic       addr_ok_w;
    logic       data_ok_w;

    // Saturating increment, capped at the starvation limit.
    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        if (v >= LIMIT_C)
            return LIMIT_C;
        return v + 4'd1;
    endfunction

    assign req_any = i_valid | d_valid;
    // dbus wins contention unless ibus has been passed over LIMIT times.
    assign grant_d = d_valid & ~(i_valid & (starve_cnt == LIMIT_C));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (req_any) state_nxt = S_ADDR;
            S_ADDR: if (m_addr_ok) state_nxt = m_data_ok ? S_IDLE : S_DATA;
            S_DATA: if (m_data_ok) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Responses are only honoured in the phase that expects them; anything
    // arriving in IDLE, or data_ok before acceptance, falls through here.
    always_comb begin
        addr_ok_w = (state == S_ADDR) && m_addr_ok;
        data_ok_w = ((state == S_ADDR) && m_addr_ok && m_data_ok) ||
                    ((state == S_DATA) && m_data_ok);
        m_valid   = (state == S_ADDR);
        i_addr_ok = addr_ok_w & ~owner_d;
        i_data_ok = data_ok_w & ~owner_d;
        d_addr_ok = addr_ok_w & owner_d;
        d_data_ok = data_ok_w & owner_d;
    end

    assign rdata = m_rdata;

    // Grant: register the winner's fields for the whole transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_d  <= 1'b0;
            m_addr   <= '0;
            m_size   <= '0;
            m_strobe <= '0;
            m_wdata  <= '0;
        end else if (state == S_IDLE && req_any) begin
            owner_d  <= grant_d;
            m_addr   <= grant_d ? d_addr : i_addr;
            m_size   <= grant_d ? d_size : i_size;
            m_strobe <= grant_d ? d_strobe : '0;
            m_wdata  <= grant_d ? d_wdata : '0;
        end
    end

    // Counts dbus wins while ibus waits; any idle cycle without an ibus
    // request, or any ibus grant, resets the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            starve_cnt <= 4'd0;
        else if (state == S_IDLE) begin
            if (i_valid && grant_d)
                starve_cnt <= sat_inc(starve_cnt);
            else
                starve_cnt <= 4'd0;
        end
    end

endmodule
